ch0re_ifetch: RTL and testbench

CH0RE_IFETCH -- requirements
Module: ch0re_ifetch

---
 rtl/ch0re_ifetch.sv | 116 +++++++++++
 tb/tb_ch0re_ifetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ch0re_ifetch.sv
// Instruction fetch: keeps up to two memory requests in flight, queues {pc, instr}
// pairs for decode in a 2-entry FIFO, and discards stale responses after a redirect.
module ch0re_ifetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req,
  output logic [63:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_redirect,
  input  logic [63:0] i_redirect_pc,
  input  logic        i_stall,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [63:0] o_pc
);

  typedef enum logic {RUN, FLUSH} state_t;
  state_t r_state, w_state_nxt;

  logic [63:0] r_fpc;
  logic [1:0]  r_outs, r_drop;
  logic [63:0] r_tag [2];
  logic        r_tag_wr, r_tag_rd;
  logic [63:0] r_fq_pc [2];
  logic [31:0] r_fq_ins [2];
  logic        r_fq_wr, r_fq_rd;
  logic [1:0]  r_fq_cnt;

  logic        w_req, w_acc, w_rsp, w_push, w_pop;
  logic [1:0]  w_outs_nxt, w_drop_nxt;
  logic        w_unused;

  assign w_unused = ^i_redirect_pc[1:0];

  // Queue slots plus in-flight requests never exceed the queue depth, so a push never overflows.
  assign w_req = !rst && (r_state == RUN) &&
                 (({1'b0, r_fq_cnt} + {1'b0, r_outs}) < 3'(FQ_DEPTH));
  assign w_acc      = w_req && i_imem_gnt;
  assign w_rsp      = i_imem_rvalid && (r_outs != 2'd0);
  assign w_push     = w_rsp && (r_drop == 2'd0) && !i_redirect;
  assign w_pop      = o_valid && !i_stall && !i_redirect;
  assign w_outs_nxt = r_outs + {1'b0, w_acc} - {1'b0, w_rsp};

  always_comb begin
    w_drop_nxt = r_drop;
    if (i_redirect) begin
      w_drop_nxt = w_outs_nxt;
    end else if (w_rsp && (r_drop != 2'd0)) begin
      w_drop_nxt = r_drop - 2'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (i_redirect && (w_drop_nxt != 2'd0)) w_state_nxt = FLUSH;
      FLUSH:   if (w_drop_nxt == 2'd0) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_fpc    <= {RESET_PC[63:2], 2'b00};
      r_outs   <= 2'd0;
      r_drop   <= 2'd0;
      r_tag_wr <= 1'b0;
      r_tag_rd <= 1'b0;
      r_fq_wr  <= 1'b0;
      r_fq_rd  <= 1'b0;
      r_fq_cnt <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_outs  <= w_outs_nxt;
      r_drop  <= w_drop_nxt;
      if (i_redirect) begin
        r_fpc <= {i_redirect_pc[63:2], 2'b00};
      end else if (w_acc) begin
        r_fpc <= r_fpc + 64'd4;
      end
      // Tags keep following requests granted in a redirect cycle so stale responses pair up.
      if (w_acc) r_tag_wr <= !r_tag_wr;
      if (w_rsp) r_tag_rd <= !r_tag_rd;
      if (i_redirect) begin
        r_fq_wr  <= 1'b0;
        r_fq_rd  <= 1'b0;
        r_fq_cnt <= 2'd0;
      end else begin
        if (w_push) r_fq_wr <= !r_fq_wr;
        if (w_pop)  r_fq_rd <= !r_fq_rd;
        r_fq_cnt <= r_fq_cnt + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) r_tag[r_tag_wr] <= r_fpc;
    if (w_push) begin
      r_fq_pc[r_fq_wr]  <= r_tag[r_tag_rd];
      r_fq_ins[r_fq_wr] <= i_imem_rdata;
    end
  end

  assign o_imem_req  = w_req;
  assign o_imem_addr = r_fpc;
  assign o_valid     = !rst && (r_fq_cnt != 2'd0);
  assign o_instr     = o_valid ? r_fq_ins[r_fq_rd] : 32'h0000_0013;
  assign o_pc        = o_valid ? r_fq_pc[r_fq_rd] : 64'h0;

endmodule

// File: tb/tb_ch0re_ifetch.sv
// Directed bench for ch0re_ifetch: an in-order memory model answers grants, and a
// scoreboard of expected fetch PCs is checked against every instruction decode consumes.
module tb_ch0re_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        valid;
  logic [31:0] instr;
  logic [63:0] pc;

  int total = 0;
  int bad   = 0;
  int n_cons = 0;
  logic resp_en;
  logic [63:0] exp_q[$];
  logic [63:0] mem_q[$];
  logic [63:0] held_pc;
  logic        found;

  ch0re_ifetch #(.RESET_PC(64'h1000), .FQ_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(imem_gnt),
    .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata),
    .i_redirect(redirect), .i_redirect_pc(redirect_pc), .i_stall(stall),
    .o_valid(valid), .o_instr(instr), .o_pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'hA0A0_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_stream(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 64'(4 * i));
  endtask

  // One clock: score what decode consumes, record grants, then drive the next response.
  task automatic cycle();
    logic [63:0] e;
    @(negedge clk);
    if (!rst && !redirect && valid && !stall) begin
      chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("o_pc", pc, e);
        chk("o_instr", 64'(instr), 64'(instr_of(e)));
      end
      n_cons++;
    end
    if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
    @(posedge clk);
    #1;
    if (resp_en && mem_q.size() != 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = instr_of(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic run_until(input int n, input int bound, input string tag);
    int start;
    int k;
    start = n_cons;
    k = 0;
    while ((n_cons - start) < n && k < bound) begin
      cycle();
      k++;
    end
    chk(tag, 64'(n_cons - start), 64'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect = 1'b0; redirect_pc = 64'h0; stall = 1'b0; resp_en = 1'b1;

    // Reset values
    cycle();
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'h13);
    chk("rst_pc", pc, 64'h0);
    chk("rst_req", 64'(imem_req), 64'd0);
    cycle();
    rst = 1'b0;
    #1;
    chk("post_rst_req", 64'(imem_req), 64'd1);
    chk("post_rst_addr", imem_addr, 64'h1000);

    // Streaming from RESET_PC
    push_stream(64'h1000, 32);
    run_until(8, 40, "stream_count");

    // Back-pressure: hold the head, stop requesting once full
    stall = 1'b1;
    repeat (5) cycle();
    chk("bp_req", 64'(imem_req), 64'd0);
    chk("bp_valid", 64'(valid), 64'd1);
    chk("bp_head", pc, exp_q[0]);
    held_pc = pc;
    cycle();
    chk("bp_hold", pc, held_pc);
    stall = 1'b0;
    run_until(6, 30, "bp_release_count");

    // Redirect with two requests outstanding
    resp_en = 1'b0;
    repeat (6) cycle();
    chk("out2_valid", 64'(valid), 64'd0);
    chk("out2_req", 64'(imem_req), 64'd0);
    chk("out2_mem", 64'(mem_q.size()), 64'd2);
    redirect = 1'b1; redirect_pc = 64'h2002;
    exp_q.delete();
    push_stream(64'h2000, 16);
    resp_en = 1'b1;
    cycle();
    redirect = 1'b0;
    chk("flush_req0", 64'(imem_req), 64'd0);
    chk("flush_valid0", 64'(valid), 64'd0);
    cycle();
    chk("flush_req1", 64'(imem_req), 64'd0);
    cycle();
    chk("flush_done_req", 64'(imem_req), 64'd1);
    chk("flush_done_addr", imem_addr, 64'h2000);
    run_until(4, 30, "redir_count");

    // Redirect in a cycle that both pushes and pops the FIFO
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      cycle();
      if (valid && imem_rvalid && !imem_req) found = 1'b1;
    end
    chk("pushpop_found", 64'(found), 64'd1);
    redirect = 1'b1; redirect_pc = 64'h3000;
    exp_q.delete();
    push_stream(64'h3000, 8);
    cycle();
    redirect = 1'b0;
    chk("pushpop_valid", 64'(valid), 64'd0);
    chk("pushpop_req", 64'(imem_req), 64'd1);
    chk("pushpop_addr", imem_addr, 64'h3000);

    // Redirect while a request is granted: that request must be dropped; also PC wrap
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    exp_q.delete();
    push_stream(64'hFFFF_FFFF_FFFF_FFFC, 16);
    cycle();
    redirect = 1'b0;
    chk("gntredir_req", 64'(imem_req), 64'd0);
    chk("gntredir_valid", 64'(valid), 64'd0);
    cycle();
    chk("wrap_first_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle();
    chk("wrap_second_req", 64'(imem_req), 64'd1);
    chk("wrap_second_addr", imem_addr, 64'h0);
    run_until(4, 30, "wrap_count");

    // Mid-operation reset with one request outstanding, then a late response
    imem_gnt = 1'b0;
    repeat (5) cycle();
    chk("idle_valid", 64'(valid), 64'd0);
    imem_gnt = 1'b1; resp_en = 1'b0;
    cycle();
    chk("midrst_pending", 64'(mem_q.size()), 64'd1);
    rst = 1'b1; resp_en = 1'b1;
    cycle();
    chk("midrst_valid", 64'(valid), 64'd0);
    chk("midrst_req", 64'(imem_req), 64'd0);
    chk("midrst_late_rvalid", 64'(imem_rvalid), 64'd1);
    rst = 1'b0;
    exp_q.delete();
    push_stream(64'h1000, 8);
    #1;
    chk("midrst_addr", imem_addr, 64'h1000);
    cycle();
    chk("late_ignored_valid", 64'(valid), 64'd0);
    run_until(3, 20, "midrst_count");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
